pcie_endpoint_ctrl: RTL and testbench



---
 rtl/pcie_endpoint_ctrl_if.sv | 23 ++
 rtl/pcie_endpoint_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pcie_endpoint_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_endpoint_ctrl_if.sv
// axi4_if: AXI4-Lite channel bundle used by pcie_endpoint_ctrl's register port.
interface axi4_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  modport slave (input awaddr, awprot, awvalid, output awready, input wdata, wstrb, wvalid,
                 output wready, output bresp, bvalid, input bready, input araddr, arprot,
                 arvalid, output arready, output rdata, rresp, rvalid, input rready);
  modport master (output awaddr, awprot, awvalid, input awready, output wdata, wstrb, wvalid,
                  input wready, input bresp, bvalid, output bready, output araddr, arprot,
                  arvalid, input arready, input rdata, rresp, rvalid, output rready);
endinterface

// File: rtl/pcie_endpoint_ctrl.sv
// pcie_endpoint_ctrl: LTSSM bring-up, AXI-Lite register file, single-descriptor DMA sequencer, MSI.
// PCIE_FAST_TRAIN_EN shortens the LTSSM state durations to 2/2/2 cycles.
module pcie_endpoint_ctrl #(
  parameter int LANES      = 16,
  parameter int GEN        = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      pcie_rx_p,
  input  logic [LANES-1:0]      pcie_rx_n,
  output logic [LANES-1:0]      pcie_tx_p,
  output logic [LANES-1:0]      pcie_tx_n,
  axi4_if.slave                 axi_if,
  output logic                  dma_req_valid,
  input  logic                  dma_req_ready,
  output logic [ADDR_WIDTH-1:0] dma_src_addr,
  output logic [ADDR_WIDTH-1:0] dma_dst_addr,
  output logic [31:0]           dma_length,
  output logic                  dma_write,
  input  logic                  dma_done,
  input  logic                  dma_error,
  input  logic [15:0]           device_id,
  input  logic [15:0]           vendor_id,
  output logic                  link_up,
  output logic [3:0]            link_width,
  output logic [2:0]            link_speed,
  output logic [31:0]           msi_vector,
  output logic                  msi_valid,
  input  logic                  msi_ready,
  output logic                  correctable_error,
  output logic                  uncorrectable_error,
  output logic [15:0]           error_code
);
`ifdef PCIE_FAST_TRAIN_EN
  localparam logic [4:0] D_DET = 5'd2, D_POL = 5'd2, D_CFG = 5'd2;
`else
  localparam logic [4:0] D_DET = 5'd8, D_POL = 5'd16, D_CFG = 5'd16;
`endif
  localparam logic [3:0] LW  = 4'($clog2(LANES));
  localparam logic [2:0] SPD = 3'(GEN);
  typedef enum logic [1:0] {DETECT, POLLING, CONFIG, L0} ltssm_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} dma_t;
  ltssm_t lt;
  dma_t ds;
  logic [4:0] cnt, dur;
  logic [63:0] src, dst;
  logic [31:0] len, wd, rmux;
  logic [7:0] waddr, raddr;
  logic [1:0] pend, ev, clr, pend_n;
  logic dir, auto, done_st, err_st;
  logic adv, enter_l0, wr, rd, start, go, bad, w28, w30, unused;
  function automatic logic mapped(input logic [7:0] a);
    return a inside {8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30};
  endfunction
  assign unused = ^{pcie_rx_p, pcie_rx_n, axi_if.awprot, axi_if.arprot, axi_if.wstrb,
                    axi_if.awaddr[31:8], axi_if.araddr[31:8], DATA_WIDTH != 0};
  assign waddr = axi_if.awaddr[7:0];
  assign raddr = axi_if.araddr[7:0];
  assign wd = axi_if.wdata;
  assign wr = axi_if.awvalid && axi_if.wvalid && !axi_if.bvalid && !rst;
  assign rd = axi_if.arvalid && !axi_if.rvalid && !rst;
  assign axi_if.awready = wr;
  assign axi_if.wready = wr;
  assign axi_if.arready = rd;
  always_comb begin
    dur = lt == DETECT ? D_DET : lt == POLLING ? D_POL : D_CFG;
    adv = lt != L0 && cnt == dur - 5'd1;
    enter_l0 = adv && lt == CONFIG;
    start = wr && waddr == 8'h24 && wd[0];
    go = ds == IDLE && (start || (enter_l0 && auto));
    w28 = wr && waddr == 8'h28;
    w30 = wr && waddr == 8'h30;
    bad = (wr && !mapped(waddr)) || (rd && !mapped(raddr));
    // Error wins over a simultaneous done; completions outside WAIT are ignored.
    ev = ds == WAIT ? {dma_error, dma_done && !dma_error} : 2'b00;
    clr = msi_valid && msi_ready ? msi_vector[1:0] : 2'b00;
    pend_n = (pend & ~clr) | ev;
    rmux = '0;
    case (raddr)
      8'h00: rmux = {device_id, vendor_id};
      8'h04: rmux = 32'h0010_0007;
      8'h08: rmux = 32'h0604_0001;
      8'h10: rmux = src[31:0];
      8'h14: rmux = src[63:32];
      8'h18: rmux = dst[31:0];
      8'h1C: rmux = dst[63:32];
      8'h20: rmux = len;
      8'h24: rmux = {29'b0, auto, dir, 1'b0};
      8'h28: rmux = {29'b0, err_st, done_st, ds != IDLE};
      8'h2C: rmux = {24'b0, link_speed, link_width, link_up};
      8'h30: rmux = {16'b0, error_code};
      default: rmux = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lt <= DETECT; cnt <= '0; ds <= IDLE;
      src <= '0; dst <= '0; len <= 32'h1000; dir <= 1'b0; auto <= 1'b1;
      done_st <= 1'b0; err_st <= 1'b0; pend <= '0;
      pcie_tx_p <= '0; pcie_tx_n <= '0;
      link_up <= 1'b0; link_width <= '0; link_speed <= '0;
      axi_if.bvalid <= 1'b0; axi_if.bresp <= '0;
      axi_if.rvalid <= 1'b0; axi_if.rresp <= '0; axi_if.rdata <= '0;
      dma_req_valid <= 1'b0; dma_src_addr <= '0; dma_dst_addr <= '0; dma_length <= '0; dma_write <= 1'b0;
      msi_valid <= 1'b0; msi_vector <= '0;
      correctable_error <= 1'b0; uncorrectable_error <= 1'b0; error_code <= '0;
    end else begin
      cnt <= adv || lt == L0 ? 5'd0 : cnt + 5'd1;
      lt <= adv ? ltssm_t'(lt + 2'd1) : lt;
      link_up <= link_up || enter_l0;
      link_width <= link_up || enter_l0 ? LW : 4'd0;
      link_speed <= link_up || enter_l0 ? SPD : 3'd0;
      pcie_tx_p <= lt == DETECT ? '0 : ~pcie_tx_p;
      pcie_tx_n <= lt == DETECT ? '0 : pcie_tx_p;
      if (wr) begin
        axi_if.bvalid <= 1'b1;
        axi_if.bresp <= mapped(waddr) ? 2'b00 : 2'b10;
        case (waddr)
          8'h10: src[31:0] <= wd;
          8'h14: src[63:32] <= wd;
          8'h18: dst[31:0] <= wd;
          8'h1C: dst[63:32] <= wd;
          8'h20: len <= wd;
          8'h24: dir <= wd[1];
          default: ;
        endcase
      end else if (axi_if.bvalid && axi_if.bready) axi_if.bvalid <= 1'b0;
      auto <= wr && waddr == 8'h24 ? wd[2] : auto && !enter_l0;
      if (rd) begin
        axi_if.rvalid <= 1'b1;
        axi_if.rresp <= mapped(raddr) ? 2'b00 : 2'b10;
        axi_if.rdata <= rmux;
      end else if (axi_if.rvalid && axi_if.rready) axi_if.rvalid <= 1'b0;
      correctable_error <= bad;
      error_code <= ev[1] ? 16'h0001 : bad ? 16'h0002 : w30 ? 16'h0000 : error_code;
      uncorrectable_error <= ev[1] || (uncorrectable_error && !w30);
      done_st <= (done_st && !(w28 && wd[1])) || ev[0];
      err_st <= (err_st && !(w28 && wd[2])) || ev[1];
      case (ds)
        IDLE: if (go) begin
          ds <= REQ;
          dma_req_valid <= 1'b1;
          dma_src_addr <= src[ADDR_WIDTH-1:0];
          dma_dst_addr <= dst[ADDR_WIDTH-1:0];
          dma_length <= len;
          dma_write <= wr && waddr == 8'h24 ? wd[1] : dir;
        end
        REQ: if (dma_req_ready) begin
          ds <= WAIT;
          dma_req_valid <= 1'b0;
        end
        WAIT: if (dma_done || dma_error) ds <= IDLE;
        default: ds <= IDLE;
      endcase
      pend <= pend_n;
      // The presented vector is frozen until accepted so a later event cannot change it mid-offer.
      if (!msi_valid || msi_ready) begin
        msi_valid <= |pend_n;
        msi_vector <= {30'b0, pend_n[1], pend_n[0] && !pend_n[1]};
      end
    end
  end
endmodule

// File: tb/tb_pcie_endpoint_ctrl.sv
// tb_pcie_endpoint_ctrl: randomized self-checking bench for pcie_endpoint_ctrl with a register/DMA model.
module tb_pcie_endpoint_ctrl;
`ifdef PCIE_FAST_TRAIN_EN
  localparam int TRAIN = 6;
`else
  localparam int TRAIN = 40;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] rx_p = '0, rx_n = '0, tx_p, tx_n;
  logic dma_req_valid, dma_req_ready = 1'b0, dma_write, dma_done = 1'b0, dma_error = 1'b0;
  logic [63:0] dma_src_addr, dma_dst_addr;
  logic [31:0] dma_length, msi_vector;
  logic link_up, msi_valid, msi_ready = 1'b0, correctable_error, uncorrectable_error;
  logic [3:0] link_width;
  logic [2:0] link_speed;
  logic [15:0] error_code;
  axi4_if axi();
  pcie_endpoint_ctrl dut (
    .clk(clk), .rst(rst), .pcie_rx_p(rx_p), .pcie_rx_n(rx_n), .pcie_tx_p(tx_p), .pcie_tx_n(tx_n),
    .axi_if(axi.slave), .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_length(dma_length),
    .dma_write(dma_write), .dma_done(dma_done), .dma_error(dma_error),
    .device_id(16'h1234), .vendor_id(16'h5678), .link_up(link_up), .link_width(link_width),
    .link_speed(link_speed), .msi_vector(msi_vector), .msi_valid(msi_valid), .msi_ready(msi_ready),
    .correctable_error(correctable_error), .uncorrectable_error(uncorrectable_error),
    .error_code(error_code));
  int errors = 0, checks = 0;
  logic [31:0] shadow [5];
  logic m_dir;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = 4'hF; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    #1;
    while (!axi.awready && t < 20) begin tick(); t++; end
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1) begin errors++; $display("FAIL axi_wr_bvalid addr=%h got=%b exp=1", a, axi.bvalid); end
    resp = axi.bresp;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output logic corr);
    int t = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    #1;
    while (!axi.arready && t < 20) begin tick(); t++; end
    tick();
    axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b1) begin errors++; $display("FAIL axi_rd_rvalid addr=%h got=%b exp=1", a, axi.rvalid); end
    d = axi.rdata; resp = axi.rresp; corr = correctable_error;
  endtask

  task automatic program_desc(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
    logic [1:0] r;
    logic [31:0] v [5];
    v = '{s[31:0], s[63:32], d[31:0], d[63:32], l};
    for (int k = 0; k < 5; k++) begin
      axi_wr(32'h10 + 32'(4 * k), v[k], r);
      shadow[k] = v[k];
    end
  endtask

  task automatic test_reset();
    logic [15:0] p;
    rst = 1'b1;
    tick(3);
    checks++;
    if ({link_up, tx_p, tx_n, dma_req_valid, msi_valid, error_code, uncorrectable_error} !== '0) begin
      errors++; $display("FAIL reset_outputs got link=%b tx_p=%h dma=%b msi=%b code=%h exp all 0",
                          link_up, tx_p, dma_req_valid, msi_valid, error_code);
    end
    rst = 1'b0;
    tick(TRAIN - 1);
    checks++;
    if (link_up !== 1'b0) begin errors++; $display("FAIL link_up_early got=%b exp=0", link_up); end
    tick();
    checks++;
    if ({link_up, link_width, link_speed} !== {1'b1, 4'd4, 3'd4}) begin
      errors++; $display("FAIL link_l0 got up=%b w=%0d s=%0d exp 1/4/4", link_up, link_width, link_speed);
    end
    p = tx_p;
    tick();
    checks++;
    if (tx_p !== ~p || tx_n !== ~tx_p) begin errors++; $display("FAIL tx_toggle got p=%h n=%h exp p=%h", tx_p, tx_n, ~p); end
  endtask

  task automatic test_auto_dma();
    logic [31:0] d; logic [1:0] r; logic c; logic [31:0] v;
    checks++;
    if ({dma_req_valid, dma_length, dma_src_addr, dma_write} !== {1'b1, 32'h1000, 64'h0, 1'b0}) begin
      errors++; $display("FAIL auto_req got v=%b len=%h src=%h exp v=1 len=1000 src=0", dma_req_valid, dma_length, dma_src_addr);
    end
    tick($urandom_range(1, 5));
    checks++;
    if (dma_req_valid !== 1'b1 || dma_length !== 32'h1000) begin
      errors++; $display("FAIL auto_req_hold got v=%b len=%h exp 1/1000", dma_req_valid, dma_length);
    end
    dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
    checks++;
    if (dma_req_valid !== 1'b0) begin errors++; $display("FAIL req_drop got=%b exp=0", dma_req_valid); end
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    checks++;
    if (msi_valid !== 1'b1 || msi_vector !== 32'h1) begin
      errors++; $display("FAIL msi_done got v=%b vec=%h exp 1/1", msi_valid, msi_vector);
    end
    axi_rd(32'h28, d, r, c);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL status_done got=%h exp=2", d); end
    v = msi_vector;
    tick($urandom_range(2, 6));
    checks++;
    if (msi_valid !== 1'b1 || msi_vector !== v) begin
      errors++; $display("FAIL msi_hold got v=%b vec=%h exp 1/%h", msi_valid, msi_vector, v);
    end
    msi_ready = 1'b1; tick(); msi_ready = 1'b0;
    checks++;
    if (msi_valid !== 1'b0) begin errors++; $display("FAIL msi_clear got=%b exp=0", msi_valid); end
    axi_wr(32'h28, 32'h2, r);
    axi_rd(32'h28, d, r, c);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_w1c got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d, v; logic [1:0] r; logic c; int k;
    logic [31:0] exp_ro [4];
    logic [7:0] ro_addr [4];
    exp_ro = '{32'h12345678, 32'h00100007, 32'h06040001, 32'((4 << 5) | (4 << 1) | 1)};
    ro_addr = '{8'h00, 8'h04, 8'h08, 8'h2C};
    for (int i = 0; i < 4; i++) begin
      axi_rd(32'(ro_addr[i]), d, r, c);
      checks++;
      if (d !== exp_ro[i] || r !== 2'b00) begin
        errors++; $display("FAIL ro_reg addr=%h got=%h/%b exp=%h/00", ro_addr[i], d, r, exp_ro[i]);
      end
    end
    axi_rd(32'h24, d, r, c);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_auto_cleared got=%h exp=0", d); end
    shadow = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1000};
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 4);
      v = $urandom;
      axi_wr(32'h10 + 32'(4 * k), v, r);
      shadow[k] = v;
      for (int j = 0; j < 5; j++) begin
        axi_rd(32'h10 + 32'(4 * j), d, r, c);
        checks++;
        if (d !== shadow[j] || r !== 2'b00) begin
          errors++; $display("FAIL reg_rw addr=%h got=%h exp=%h", 32'h10 + 4 * j, d, shadow[j]);
        end
      end
    end
  endtask

  task automatic test_dma_random();
    logic [63:0] s, dd; logic [31:0] l, d; logic [1:0] r; logic c; int o;
    dma_done = 1'b1; dma_error = 1'b1; tick(); dma_done = 1'b0; dma_error = 1'b0;
    checks++;
    if (msi_valid !== 1'b0 || uncorrectable_error !== 1'b0) begin
      errors++; $display("FAIL idle_done_ignored got msi=%b unc=%b exp 0/0", msi_valid, uncorrectable_error);
    end
    for (int i = 0; i < 5; i++) begin
      s = i == 0 ? 64'h100 : {$urandom, $urandom};
      dd = {$urandom, $urandom};
      l = i == 0 ? 32'd64 : $urandom;
      m_dir = 1'($urandom);
      program_desc(s, dd, l);
      axi_wr(32'h24, {30'b0, m_dir, 1'b1}, r);
      checks++;
      if ({dma_req_valid, dma_src_addr, dma_dst_addr, dma_length, dma_write} !== {1'b1, s, dd, l, m_dir}) begin
        errors++; $display("FAIL desc got v=%b src=%h dst=%h len=%h w=%b exp src=%h dst=%h len=%h w=%b",
                            dma_req_valid, dma_src_addr, dma_dst_addr, dma_length, dma_write, s, dd, l, m_dir);
      end
      axi_wr(32'h10, ~s[31:0], r);
      shadow[0] = ~s[31:0];
      axi_wr(32'h24, {30'b0, m_dir, 1'b1}, r);
      axi_rd(32'h28, d, r, c);
      checks++;
      if (dma_src_addr !== s || d[0] !== 1'b1) begin
        errors++; $display("FAIL busy_start_ignored got src=%h busy=%b exp src=%h busy=1", dma_src_addr, d[0], s);
      end
      tick($urandom_range(0, 3));
      dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
      tick($urandom_range(0, 3));
      o = i == 0 ? 1 : $urandom_range(0, 2);
      dma_done = o != 1; dma_error = o != 0; tick(); dma_done = 1'b0; dma_error = 1'b0;
      checks++;
      if ({msi_valid, msi_vector, uncorrectable_error, error_code} !==
          {1'b1, o == 0 ? 32'h1 : 32'h2, o != 0, o == 0 ? 16'h0 : 16'h1}) begin
        errors++; $display("FAIL dma_outcome o=%0d got msi=%b vec=%h unc=%b code=%h", o, msi_valid, msi_vector,
                            uncorrectable_error, error_code);
      end
      axi_rd(32'h28, d, r, c);
      checks++;
      if (d !== (o == 0 ? 32'h2 : 32'h4)) begin errors++; $display("FAIL dma_status o=%0d got=%h exp=%h", o, d, o == 0 ? 2 : 4); end
      msi_ready = 1'b1; tick(); msi_ready = 1'b0;
      axi_wr(32'h28, 32'h6, r);
      axi_wr(32'h30, $urandom, r);
      checks++;
      if ({msi_valid, uncorrectable_error, error_code} !== '0) begin
        errors++; $display("FAIL err_clear got msi=%b unc=%b code=%h exp 0", msi_valid, uncorrectable_error, error_code);
      end
    end
  endtask

  task automatic test_msi_priority();
    logic [1:0] r;
    axi_wr(32'h24, 32'h1, r);
    dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    axi_wr(32'h24, 32'h1, r);
    dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
    dma_error = 1'b1; tick(); dma_error = 1'b0;
    checks++;
    if (msi_valid !== 1'b1 || msi_vector !== 32'h1) begin
      errors++; $display("FAIL msi_stable got v=%b vec=%h exp 1/1", msi_valid, msi_vector);
    end
    msi_ready = 1'b1; tick();
    checks++;
    if (msi_valid !== 1'b1 || msi_vector !== 32'h2) begin
      errors++; $display("FAIL msi_next got v=%b vec=%h exp 1/2", msi_valid, msi_vector);
    end
    tick(); msi_ready = 1'b0;
    checks++;
    if (msi_valid !== 1'b0) begin errors++; $display("FAIL msi_drain got=%b exp=0", msi_valid); end
    axi_wr(32'h28, 32'h6, r);
    axi_wr(32'h30, 32'h0, r);
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; logic c;
    axi_rd(32'h80, d, r, c);
    checks++;
    if ({d, r, c, error_code} !== {32'h0, 2'b10, 1'b1, 16'h0002}) begin
      errors++; $display("FAIL unmapped_rd got d=%h resp=%b corr=%b code=%h exp 0/10/1/0002", d, r, c, error_code);
    end
    tick();
    checks++;
    if (correctable_error !== 1'b0) begin errors++; $display("FAIL corr_pulse got=%b exp=0", correctable_error); end
    axi_wr(32'h0C, 32'hDEAD, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL unmapped_wr got=%b exp=10", r); end
    axi_wr(32'h30, 32'h0, r);
    checks++;
    if (error_code !== 16'h0) begin errors++; $display("FAIL code_clear got=%h exp=0", error_code); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; logic c;
    axi_wr(32'h24, 32'h1, r);
    dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    axi_rd(32'h84, d, r, c);
    program_desc({$urandom, $urandom}, 64'h0, 32'h40);
    axi_wr(32'h24, 32'h1, r);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({dma_req_valid, link_up, link_width, link_speed, tx_p, tx_n, msi_valid, msi_vector, error_code,
         uncorrectable_error, correctable_error, dma_length, dma_src_addr} !== '0) begin
      errors++; $display("FAIL mid_reset got dma=%b link=%b msi=%b vec=%h code=%h len=%h src=%h exp all 0",
                          dma_req_valid, link_up, msi_valid, msi_vector, error_code, dma_length, dma_src_addr);
    end
    tick(TRAIN);
    checks++;
    if ({link_up, dma_req_valid, dma_length} !== {1'b1, 1'b1, 32'h1000}) begin
      errors++; $display("FAIL retrain got up=%b dma=%b len=%h exp 1/1/1000", link_up, dma_req_valid, dma_length);
    end
  endtask

  initial begin
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0; axi.bready = 1'b1; axi.rready = 1'b1;
    axi.awaddr = '0; axi.wdata = '0; axi.wstrb = '0; axi.araddr = '0; axi.awprot = '0; axi.arprot = '0;
    test_reset();
    test_auto_dma();
    test_regs();
    test_dma_random();
    test_msi_priority();
    test_unmapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
